bird_plotter: RTL

//  Pixel-write initiator for the 160x120 vga_adapter plot port (x, y, colour, plot).
//  On each request it erases the previously drawn bird sprite box, then draws the sprite at a new position.

---
 rtl/bird_plotter_pkg.sv | 19 +
 rtl/bird_plotter_raster_counter.sv | 44 ++++
 rtl/bird_plotter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bird_plotter_pkg.sv
// Shared screen geometry, coordinate/colour widths and FSM state type for the bird sprite plotter.
package bird_plotter_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] ERASE_COLOUR = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } plot_state_t;

endpackage

// File: rtl/bird_plotter_raster_counter.sv
// Walks one pixel index over the sprite box in raster order, keeping col/row alongside it.
module bird_plotter_raster_counter #(
    parameter int SPR_W = 5,
    parameter int SPR_H = 4,
    parameter int IDX_W = $clog2(SPR_W * SPR_H),
    parameter int COL_W = $clog2(SPR_W),
    parameter int ROW_W = $clog2(SPR_H)
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             clear,
    input  logic             enable,
    output logic [IDX_W-1:0] idx,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    localparam int N = SPR_W * SPR_H;

    assign last = (idx == IDX_W'(N - 1));

    // advance index and col/row together; wrap to pixel 0 after the last pixel so phases chain
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            idx <= '0;
            col <= '0;
            row <= '0;
        end else if (clear || (enable && last)) begin
            idx <= '0;
            col <= '0;
            row <= '0;
        end else if (enable) begin
            idx <= idx + 1'b1;
            if (col == COL_W'(SPR_W - 1)) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bird_plotter.sv
// Erases the previously drawn bird box, then draws the sprite bitmap at the new position,
// emitting one pixel write per cycle on the VGA adapter plot port.
//
// state | meaning
// IDLE  | waiting for go; plot low
// ERASE | writing ERASE_COLOUR over the old box, one pixel per cycle
// DRAW  | writing opaque sprite pixels over the new box
// DONE  | pulse done, drop busy, remember the new box as the old one
module bird_plotter
    import bird_plotter_pkg::*;
#(
    parameter int SPR_W = 5,
    parameter int SPR_H = 4
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   go,
    input  logic [X_W-1:0]         pos_x,
    input  logic [Y_W-1:0]         pos_y,
    input  logic [SPR_W*SPR_H-1:0] pattern,
    input  logic [COLOUR_W-1:0]    sprite_colour,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [COLOUR_W-1:0]    colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);

    localparam int N     = SPR_W * SPR_H;
    localparam int IDX_W = $clog2(N);
    localparam int COL_W = $clog2(SPR_W);
    localparam int ROW_W = $clog2(SPR_H);

    plot_state_t         state;
    logic [X_W-1:0]      old_x, new_x;
    logic [Y_W-1:0]      old_y, new_y;
    logic                old_valid;
    logic [N-1:0]        pat_q;
    logic [COLOUR_W-1:0] spr_colour_q;

    logic [IDX_W-1:0]    idx;
    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic                last;

    logic [X_W:0]        px;
    logic [Y_W:0]        py;
    logic                on_screen;

    bird_plotter_raster_counter #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_counter (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .clear    (state == ST_IDLE),
        .enable   ((state == ST_ERASE) || (state == ST_DRAW)),
        .idx      (idx),
        .col      (col),
        .row      (row),
        .last     (last)
    );

    // pixel coordinate one bit wider than the port so boxes near the edge never wrap back on-screen
    always_comb begin
        px        = (state == ST_ERASE) ? {1'b0, old_x} : {1'b0, new_x};
        py        = (state == ST_ERASE) ? {1'b0, old_y} : {1'b0, new_y};
        px        = px + (X_W + 1)'(col);
        py        = py + (Y_W + 1)'(row);
        on_screen = (px < (X_W + 1)'(SCREEN_W)) && (py < (Y_W + 1)'(SCREEN_H));
    end

    // sequencing FSM with registered plot-port outputs
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            x            <= '0;
            y            <= '0;
            colour       <= '0;
            plot         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            old_x        <= '0;
            old_y        <= '0;
            old_valid    <= 1'b0;
            new_x        <= '0;
            new_y        <= '0;
            pat_q        <= '0;
            spr_colour_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (go) begin
                        new_x        <= pos_x;
                        new_y        <= pos_y;
                        pat_q        <= pattern;
                        spr_colour_q <= sprite_colour;
                        busy         <= 1'b1;
                        state        <= old_valid ? ST_ERASE : ST_DRAW;
                    end
                end
                ST_ERASE: begin
                    x      <= px[X_W-1:0];
                    y      <= py[Y_W-1:0];
                    colour <= ERASE_COLOUR;
                    plot   <= on_screen;
                    if (last) state <= ST_DRAW;
                end
                ST_DRAW: begin
                    x      <= px[X_W-1:0];
                    y      <= py[Y_W-1:0];
                    colour <= spr_colour_q;
                    plot   <= pat_q[idx] && on_screen;
                    if (last) state <= ST_DONE;
                end
                ST_DONE: begin
                    plot      <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    old_x     <= new_x;
                    old_y     <= new_y;
                    old_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
